// File: rtl/risc_pkg.sv
// Shared types and constants for the instruction fetch slice.
package risc_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam int          INSTR_BYTES = 4;
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

endpackage

// File: rtl/fetch_unit_queue.sv
// Circular buffer of {pc, instr} entries between fetch and decode.
module fetch_queue
    import risc_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  fetch_entry_t             push_data,
    input  logic                     pop,
    output fetch_entry_t             head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign head    = mem[rd_ptr];

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; entries are only visible while count covers them.
    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC register, instruction memory request, fault detection and decode queue.
module fetch_unit
    import risc_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          QUEUE_DEPTH = 2,
    parameter int          IMEM_BYTES  = 128
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_en,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        if_ready,
    output logic        fetch_fault
);

    localparam logic [31:0] LAST_ADDR = 32'(IMEM_BYTES - INSTR_BYTES);

    logic [31:0]                  pc_q;
    logic                         bad_pc;
    logic                         pop;
    logic                         can_push;
    logic                         q_full;
    logic                         q_empty;
    logic [$clog2(QUEUE_DEPTH):0] q_count;
    fetch_entry_t                 q_head;
    fetch_entry_t                 push_data;

    assign bad_pc    = (pc_q[1:0] != 2'b00) | (pc_q > LAST_ADDR);
    assign pop       = if_valid & if_ready & ~redirect_valid;
    assign can_push  = ~q_full | pop;
    // Gated by rst so no request escapes while reset is held.
    assign imem_req  = ~rst & fetch_en & can_push & ~fetch_fault & ~redirect_valid & ~bad_pc;
    assign imem_addr = pc_q;
    assign push_data = '{pc: pc_q, instr: imem_data};

    assign if_valid  = ~q_empty;
    assign if_pc     = (q_count != '0) ? q_head.pc    : '0;
    assign if_instr  = (q_count != '0) ? q_head.instr : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else if (redirect_valid) begin
            pc_q <= redirect_pc;
        end else if (imem_req) begin
            pc_q <= pc_q + 32'(INSTR_BYTES);
        end
    end

    // Sticky until reset; a redirect does not clear it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_fault <= 1'b0;
        end else if (fetch_en && !fetch_fault && !redirect_valid && bad_pc) begin
            fetch_fault <= 1'b1;
        end
    end

    fetch_queue #(
        .DEPTH(QUEUE_DEPTH)
    ) u_queue (
        .clk      (clk),
        .rst      (rst),
        .flush    (redirect_valid),
        .push     (imem_req),
        .push_data(push_data),
        .pop      (pop),
        .head     (q_head),
        .count    (q_count),
        .full     (q_full),
        .empty    (q_empty)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit against a queue-based behavioural model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_en;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_ready;
    logic        fetch_fault;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] rom [32];

    // Behavioural model state
    logic [63:0] mq [$];
    logic [31:0] m_pc;
    bit          m_fault;

    // Expected outputs for the current cycle
    bit          e_req, e_valid, e_fault, e_pop, e_bad;
    logic [31:0] e_addr, e_pc, e_instr;

    always #5 clk = ~clk;

    assign imem_data = (imem_addr < 32'd128) ? rom[imem_addr[6:2]] : 32'hDEAD_BEEF;

    fetch_unit #(
        .RESET_PC   (32'h0),
        .QUEUE_DEPTH(2),
        .IMEM_BYTES (128)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .fetch_en      (fetch_en),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .if_valid      (if_valid),
        .if_instr      (if_instr),
        .if_pc         (if_pc),
        .if_ready      (if_ready),
        .fetch_fault   (fetch_fault)
    );

    function automatic void model_reset();
        mq.delete();
        m_pc    = 32'h0;
        m_fault = 1'b0;
    endfunction

    function automatic void compute_exp();
        e_bad   = (m_pc % 4 != 0) || (m_pc > 32'd124);
        e_valid = (mq.size() > 0);
        e_pc    = e_valid ? mq[0][63:32] : 32'h0;
        e_instr = e_valid ? mq[0][31:0]  : 32'h0;
        e_pop   = e_valid && if_ready;
        e_req   = !rst && fetch_en && (mq.size() < 2 || e_pop) && !m_fault
                  && !redirect_valid && !e_bad;
        e_addr  = m_pc;
        e_fault = m_fault;
    endfunction

    task automatic drive(input bit en, input bit rdy, input bit rv, input logic [31:0] rpc);
        fetch_en       = en;
        if_ready       = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        compute_exp();
        #1;
    endtask

    task automatic advance();
        bit set_fault;
        set_fault = fetch_en && !m_fault && !redirect_valid && e_bad;
        @(posedge clk);
        if (redirect_valid) begin
            mq.delete();
            m_pc = redirect_pc;
        end else begin
            if (e_pop) void'(mq.pop_front());
            if (e_req) begin
                mq.push_back({m_pc, rom[m_pc[6:2]]});
                m_pc = m_pc + 32'd4;
            end
        end
        if (set_fault) m_fault = 1'b1;
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        #1;
        n_tests++;
        if ({imem_req, if_valid, if_instr, if_pc, fetch_fault, imem_addr} !== {1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0}) begin
            n_fail++;
            $display("FAIL reset_state got req=%b v=%b instr=%h pc=%h flt=%b addr=%h want all 0",
                     imem_req, if_valid, if_instr, if_pc, fetch_fault, imem_addr);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b1, 1'b0, 32'h0);
            n_tests++;
            if ({imem_req, imem_addr, if_valid, if_instr, if_pc, fetch_fault} !== {e_req, e_addr, e_valid, e_instr, e_pc, e_fault}) begin
                n_fail++;
                $display("FAIL seq c=%0d got %h want %h", i,
                         {imem_req, imem_addr, if_valid, if_instr, if_pc, fetch_fault},
                         {e_req, e_addr, e_valid, e_instr, e_pc, e_fault});
            end
            n_tests++;
            if (imem_addr !== 32'(4 * i) || imem_req !== 1'b1) begin
                n_fail++;
                $display("FAIL seq_addr c=%0d got addr=%h req=%b want addr=%h req=1", i, imem_addr, imem_req, 4 * i);
            end
            if (i == 1 || i == 2) begin
                n_tests++;
                if (if_valid !== 1'b1 || if_pc !== 32'(4 * (i - 1)) || if_instr !== rom[i - 1]) begin
                    n_fail++;
                    $display("FAIL seq_head c=%0d got v=%b pc=%h instr=%h want v=1 pc=%h instr=%h",
                             i, if_valid, if_pc, if_instr, 4 * (i - 1), rom[i - 1]);
                end
            end
            advance();
        end
    endtask

    task automatic test_backpressure();
        int          reqs;
        logic [31:0] last_pc;
        apply_reset();
        reqs = 0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 1'b0, 32'h0);
            n_tests++;
            if ({imem_req, imem_addr, if_valid, if_instr, if_pc, fetch_fault} !== {e_req, e_addr, e_valid, e_instr, e_pc, e_fault}) begin
                n_fail++;
                $display("FAIL stall c=%0d got %h want %h", i,
                         {imem_req, imem_addr, if_valid, if_instr, if_pc, fetch_fault},
                         {e_req, e_addr, e_valid, e_instr, e_pc, e_fault});
            end
            if (imem_req === 1'b1) reqs++;
            advance();
        end
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        n_tests++;
        if (reqs != 2 || imem_req !== 1'b0 || imem_addr !== 32'h8) begin
            n_fail++;
            $display("FAIL stall_hold got reqs=%0d req=%b addr=%h want reqs=2 req=0 addr=00000008", reqs, imem_req, imem_addr);
        end
        last_pc = 32'hFFFF_FFFC;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1, 1'b0, 32'h0);
            n_tests++;
            if ({imem_req, imem_addr, if_valid, if_instr, if_pc, fetch_fault} !== {e_req, e_addr, e_valid, e_instr, e_pc, e_fault}) begin
                n_fail++;
                $display("FAIL drain c=%0d got %h want %h", i,
                         {imem_req, imem_addr, if_valid, if_instr, if_pc, fetch_fault},
                         {e_req, e_addr, e_valid, e_instr, e_pc, e_fault});
            end
            if (if_valid === 1'b1) begin
                n_tests++;
                if (if_pc !== last_pc + 32'd4) begin
                    n_fail++;
                    $display("FAIL drain_order c=%0d got pc=%h want %h", i, if_pc, last_pc + 32'd4);
                end
                last_pc = if_pc;
            end
            advance();
        end
    endtask

    task automatic test_redirect();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b0, 32'h0);
            advance();
        end
        drive(1'b1, 1'b1, 1'b1, 32'h40);
        n_tests++;
        if (if_valid !== 1'b1 || imem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL redir_cycle got v=%b req=%b want v=1 req=0", if_valid, imem_req);
        end
        advance();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, 1'b0, 32'h0);
            n_tests++;
            if ({imem_req, imem_addr, if_valid, if_instr, if_pc, fetch_fault} !== {e_req, e_addr, e_valid, e_instr, e_pc, e_fault}) begin
                n_fail++;
                $display("FAIL redir c=%0d got %h want %h", i,
                         {imem_req, imem_addr, if_valid, if_instr, if_pc, fetch_fault},
                         {e_req, e_addr, e_valid, e_instr, e_pc, e_fault});
            end
            n_tests++;
            if ((i == 0 && (if_valid !== 1'b0 || imem_addr !== 32'h40)) ||
                (i >= 1 && (if_valid !== 1'b1 || if_pc !== 32'h40 + 32'(4 * (i - 1))))) begin
                n_fail++;
                $display("FAIL redir_head c=%0d got v=%b pc=%h addr=%h", i, if_valid, if_pc, imem_addr);
            end
            advance();
        end
    endtask

    task automatic test_misaligned();
        drive(1'b1, 1'b1, 1'b1, 32'h42);
        advance();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b1, (i == 3), 32'h0);
            n_tests++;
            if ({imem_req, imem_addr, if_valid, if_instr, if_pc, fetch_fault} !== {e_req, e_addr, e_valid, e_instr, e_pc, e_fault}) begin
                n_fail++;
                $display("FAIL misalign c=%0d got %h want %h", i,
                         {imem_req, imem_addr, if_valid, if_instr, if_pc, fetch_fault},
                         {e_req, e_addr, e_valid, e_instr, e_pc, e_fault});
            end
            n_tests++;
            if (imem_req !== 1'b0 || if_valid !== 1'b0 || fetch_fault !== (i >= 1)) begin
                n_fail++;
                $display("FAIL misalign_flag c=%0d got req=%b v=%b flt=%b want req=0 v=0 flt=%b",
                         i, imem_req, if_valid, fetch_fault, (i >= 1));
            end
            advance();
        end
    endtask

    task automatic test_range();
        bit saw_last;
        apply_reset();
        drive(1'b1, 1'b1, 1'b1, 32'h70);
        advance();
        saw_last = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1, 1'b0, 32'h0);
            n_tests++;
            if ({imem_req, imem_addr, if_valid, if_instr, if_pc, fetch_fault} !== {e_req, e_addr, e_valid, e_instr, e_pc, e_fault}) begin
                n_fail++;
                $display("FAIL range c=%0d got %h want %h", i,
                         {imem_req, imem_addr, if_valid, if_instr, if_pc, fetch_fault},
                         {e_req, e_addr, e_valid, e_instr, e_pc, e_fault});
            end
            if (imem_addr === 32'h7C) begin
                saw_last = 1'b1;
                n_tests++;
                if (imem_req !== 1'b1) begin
                    n_fail++;
                    $display("FAIL range_last got req=%b want 1 at addr 0000007c", imem_req);
                end
            end
            advance();
        end
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        n_tests++;
        if (!saw_last || imem_addr !== 32'h80 || imem_req !== 1'b0 || fetch_fault !== 1'b1) begin
            n_fail++;
            $display("FAIL range_end got seen7c=%b addr=%h req=%b flt=%b want 1 00000080 0 1",
                     saw_last, imem_addr, imem_req, fetch_fault);
        end
        advance();
    endtask

    task automatic test_async_reset();
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b0, 32'h0);
            advance();
        end
        #2;
        rst = 1'b1;
        #1;
        n_tests++;
        if ({imem_req, if_valid, if_instr, if_pc, fetch_fault, imem_addr} !== {1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0}) begin
            n_fail++;
            $display("FAIL async_rst got req=%b v=%b instr=%h pc=%h flt=%b addr=%h want all 0",
                     imem_req, if_valid, if_instr, if_pc, fetch_fault, imem_addr);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 1'b0, 32'h0);
            n_tests++;
            if (imem_addr !== 32'(4 * i) ||
                {imem_req, imem_addr, if_valid, if_instr, if_pc, fetch_fault} !== {e_req, e_addr, e_valid, e_instr, e_pc, e_fault}) begin
                n_fail++;
                $display("FAIL restart c=%0d got %h want %h", i,
                         {imem_req, imem_addr, if_valid, if_instr, if_pc, fetch_fault},
                         {e_req, e_addr, e_valid, e_instr, e_pc, e_fault});
            end
            advance();
        end
    endtask

    task automatic test_random();
        logic [31:0] tgt;
        bit          rv;
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            if (i % 80 == 79) apply_reset();
            rv = ($urandom_range(0, 99) < 8);
            case ($urandom_range(0, 9))
                0:       tgt = 32'($urandom_range(0, 127)) | 32'h1;
                1:       tgt = 32'h80 + 32'(4 * $urandom_range(0, 10));
                default: tgt = 32'(4 * $urandom_range(0, 31));
            endcase
            drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 9) < 6), rv, tgt);
            n_tests++;
            if ({imem_req, imem_addr, if_valid, if_instr, if_pc, fetch_fault} !== {e_req, e_addr, e_valid, e_instr, e_pc, e_fault}) begin
                n_fail++;
                $display("FAIL random c=%0d got %h want %h", i,
                         {imem_req, imem_addr, if_valid, if_instr, if_pc, fetch_fault},
                         {e_req, e_addr, e_valid, e_instr, e_pc, e_fault});
            end
            advance();
        end
    endtask

    initial begin
        rom[0] = 32'h0050_0093;
        rom[1] = 32'h00A0_0113;
        for (int i = 2; i < 32; i++) rom[i] = {8'(i), 12'h0A5, 12'h113} ^ 32'(i * 32'h0001_0200);
        rst            = 1'b1;
        fetch_en       = 1'b0;
        if_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        model_reset();

        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect();
        test_misaligned();
        test_range();
        test_async_reset();
        test_random();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
